mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares one unified, multi-cycle, line-wide main memory between the I-cache fill port and the D-cache fill/write-back port of the pipelined CPU.
- Grants one requester at a time, with D-side priority and an I-side anti-starvation bound.
- Issues a single-cycle memory command and waits for memory to respond.
- Returns line data with a one-cycle ready pulse.
- Sits between the two caches and the memory model, replacing direct IM/DM connections.

Parameters:
ADDR_W, 16, word address width from the caches
LINE_W, 64, line width (4 x 16-bit words)
STARVE_MAX, 4, consecutive D grants allowed while i_req is pending
TIMEOUT, 64, cycles in ACCESS without mem_rdy before an error response

Ports:
clk  in  1  global clock
rst_n  in  1  asynchronous reset, active low
i_req  in  1  I-side line read request; held until i_rdy
i_addr  in  ADDR_W  I-side word address; stable while i_req
i_rdy  out  1  one-cycle completion pulse to I-side
i_rd_data  out  LINE_W  line returned to I-side; valid when i_rdy
d_req  in  1  D-side request; held until d_rdy
d_we  in  1  1 = line write-back, 0 = line read
d_addr  in  ADDR_W  D-side word address
d_wr_data  in  LINE_W  write-back line
d_rdy  out  1  one-cycle completion pulse to D-side
d_rd_data  out  LINE_W  line returned to D-side; valid when d_rdy
mem_en  out  1  one-cycle command strobe to memory
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W-2  line address = granted addr[ADDR_W-1:2]
mem_wr_data  out  LINE_W  write line, qualified by mem_en
mem_rd_data  in  LINE_W  memory read line, valid with mem_rdy
mem_rdy  in  1  memory completion pulse
busy  out  1  high whenever the state is not IDLE
err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE. All outputs are 0, including err, the starvation count, the timeout count and the latched grant/addr/data.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, no request: remain in IDLE.
- IDLE, request present: pick an owner, latch owner/we/addr/wr_data, go to ACCESS.
- Arbitration (in IDLE only):
  - d_req alone -> D.
  - i_req alone -> I.
  - Both -> D, unless starve_cnt == STARVE_MAX, in which case -> I.
- Starvation counter:
  - Increments on a D grant while i_req is high.
  - Clears on any I grant, or on a D grant with i_req low.
  - Saturates at STARVE_MAX.
- ACCESS:
  - mem_en=1 only in the first ACCESS cycle, with mem_we/mem_addr/mem_wr_data driven from the latched values.
  - mem_we is forced 0 for I grants.
  - Afterwards mem_en=0. mem_addr/mem_we/mem_wr_data hold their values for the whole ACCESS.
- ACCESS exit on mem_rdy: capture mem_rd_data (captured even on writes; requester ignores it), go to RESP.
- ACCESS exit on timeout: the timeout counter counts ACCESS cycles. When it reaches TIMEOUT with no mem_rdy: set err (sticky until reset), capture data as 0, go to RESP.
- Latency: request sampled in IDLE at cycle N -> mem_en at N+1. mem_rdy at cycle M (M >= N+2) -> owner rdy=1 with data at M+1 -> IDLE at M+2.
- RESP: pulse the owner's rdy for exactly one cycle, with rd_data driven. The non-owner's rdy stays 0. rd_data outputs may hold their last value otherwise.
- Requester rule: deassert req (or present a new request) no later than the cycle after rdy. A new request is accepted at the earliest at M+2.
- Req dropped mid-transaction: ignored. The transaction completes and rdy still pulses.
- mem_rdy outside ACCESS, or a second mem_rdy in the same transaction: ignored.
- Input changes while busy: addr/data changes are ignored because values are latched at grant.
- Reset mid-operation: immediate return to IDLE with outputs 0. Any later stale mem_rdy is ignored in IDLE.
- busy=1 in ACCESS and RESP.

Decomposition:
- Package mem_arb_pkg contains:
  - state enum {IDLE, ACCESS, RESP}
  - owner enum {OWN_I, OWN_D}
  - LINE_W/ADDR_W defaults
  - line-address slice helper constant (offset bits = 2)
- Sub-module mem_arb_pick: combinational grant selection from i_req, d_req and starve_cnt == STARVE_MAX. Outputs grant_valid and grant_owner.
- FSM, counters and latches live in mem_arbiter.

Test Plan:
- I read, memory latency 4: i_req=1, i_addr=16'h0013 at cycle 0 -> mem_en=1, mem_we=0, mem_addr=14'h0004 at cycle 1 only; mem_rdy with data 64'h1111_2222_3333_4444 at cycle 5 -> i_rdy=1 with that data at cycle 6, d_rdy=0; busy=0 at cycle 7.
- D write-back: d_req=1, d_we=1, d_addr=16'h0100, d_wr_data=64'hDEAD_BEEF_0000_FFFF -> mem_en=1, mem_we=1, mem_addr=14'h0040 with that data; d_rdy is a single pulse one cycle after mem_rdy.
- Simultaneous: i_req and d_req both high, STARVE_MAX=4, D re-requests back-to-back:
  - Grants 1-4 go to D; grant 5 goes to I.
  - After the I grant, starve_cnt=0 and D wins the next contest.
- Timeout: TIMEOUT=8, d_req read, mem_rdy never asserted -> d_rdy=1 with d_rd_data=0 exactly 9 cycles after mem_en; err=1 and stays 1 through later successful transactions.
- Reset mid-operation: assert rst_n=0 during ACCESS -> all outputs 0 immediately; after release, a stale mem_rdy produces no rdy pulse; a new i_req then completes normally.
- Req dropped: i_req deasserted one cycle after grant -> the transaction still completes with an i_rdy pulse; no second mem_en is issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and defaults for the I/D main-memory arbiter.
//   state_e  : arbiter FSM states (IDLE, ACCESS, RESP)
//   owner_e  : which requester currently holds the memory (OWN_I, OWN_D)
//   ADDR_W_DEF / LINE_W_DEF : default word-address and line widths
//   LINE_OFS : word-offset bits dropped to form a line address
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LINE_W_DEF = 64;

  // A line holds 4 words, so the low 2 word-address bits select within it.
  localparam int LINE_OFS   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational grant selection for the memory arbiter.
// Ports:
//   i_req, d_req  : pending requests from the I- and D-side
//   starve_hit    : the D-side has won STARVE_MAX contests in a row
//   grant_valid   : some requester can be granted this cycle
//   grant_owner   : the requester that wins
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   starve_hit,
  output logic   grant_valid,
  output owner_e grant_owner
);

  // D-side wins ties unless the I-side has been starved long enough.
  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_D;
    if (i_req && (!d_req || starve_hit)) begin
      grant_owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one multi-cycle, line-wide main memory between the I-cache fill
// port and the D-cache fill/write-back port. One requester is served at a
// time; the D-side has priority, bounded so the I-side cannot starve.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   i_req/i_addr/i_rdy/i_rd_data    : I-side line read handshake
//   d_req/d_we/d_addr/d_wr_data     : D-side line read / write-back request
//   d_rdy/d_rd_data                 : D-side completion pulse and line
//   mem_en/mem_we/mem_addr/
//   mem_wr_data                     : single-cycle command to memory
//   mem_rd_data/mem_rdy             : memory response
//   busy                            : a transaction is in flight
//   err                             : sticky memory timeout flag
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_req,
  input  logic [ADDR_W-1:0]          i_addr,
  output logic                       i_rdy,
  output logic [LINE_W-1:0]          i_rd_data,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [ADDR_W-1:0]          d_addr,
  input  logic [LINE_W-1:0]          d_wr_data,
  output logic                       d_rdy,
  output logic [LINE_W-1:0]          d_rd_data,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-LINE_OFS-1:0] mem_addr,
  output logic [LINE_W-1:0]          mem_wr_data,
  input  logic [LINE_W-1:0]          mem_rd_data,
  input  logic                       mem_rdy,
  output logic                       busy,
  output logic                       err
);

  localparam int SCNT_W = $clog2(STARVE_MAX + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int LADR_W = ADDR_W - LINE_OFS;

  state_e              state;
  state_e              state_nxt;
  owner_e              grant_owner;
  logic                grant_valid;
  logic                starve_hit;
  logic                take_grant;
  logic                timeout_hit;

  owner_e              lat_owner;
  logic                lat_we;
  logic [LADR_W-1:0]   lat_addr;
  logic [LINE_W-1:0]   lat_wdata;
  logic [LINE_W-1:0]   rd_buf;
  logic                cmd_first;
  logic [SCNT_W-1:0]   starve_cnt;
  logic [TCNT_W-1:0]   tcnt;
  logic                err_q;

  // Word-offset bits never reach memory; only whole lines move.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[LINE_OFS-1:0], d_addr[LINE_OFS-1:0]};

  assign starve_hit = (starve_cnt == SCNT_W'(STARVE_MAX));

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .starve_hit  (starve_hit),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus all externally visible strobes. Outputs depend only on
  // registered state, so they are glitch-free with respect to the inputs.
  always_comb begin
    state_nxt   = state;
    take_grant  = 1'b0;
    timeout_hit = 1'b0;
    mem_en      = 1'b0;
    i_rdy       = 1'b0;
    d_rdy       = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_valid) begin
          take_grant = 1'b1;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = cmd_first;
        if (mem_rdy) begin
          state_nxt = RESP;
        end else if (tcnt == TCNT_W'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP: begin
        i_rdy     = (lat_owner == OWN_I);
        d_rdy     = (lat_owner == OWN_D);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latches, starvation/timeout counters and the response buffer.
  // Everything the memory sees is taken from the latches, so requester
  // inputs may change freely once the grant has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_owner  <= OWN_I;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rd_buf     <= '0;
      cmd_first  <= 1'b0;
      starve_cnt <= '0;
      tcnt       <= '0;
      err_q      <= 1'b0;
    end else if (take_grant) begin
      lat_owner <= grant_owner;
      cmd_first <= 1'b1;
      tcnt      <= '0;
      if (grant_owner == OWN_D) begin
        lat_we    <= d_we;
        lat_addr  <= d_addr[ADDR_W-1:LINE_OFS];
        lat_wdata <= d_wr_data;
      end else begin
        lat_we    <= 1'b0;
        lat_addr  <= i_addr[ADDR_W-1:LINE_OFS];
        lat_wdata <= '0;
      end
      // Only a D win over a waiting I-side counts toward starvation.
      if ((grant_owner == OWN_I) || !i_req) begin
        starve_cnt <= '0;
      end else if (!starve_hit) begin
        starve_cnt <= starve_cnt + SCNT_W'(1);
      end
    end else if (state == ACCESS) begin
      cmd_first <= 1'b0;
      if (mem_rdy) begin
        rd_buf <= mem_rd_data;
      end else if (timeout_hit) begin
        rd_buf <= '0;
        err_q  <= 1'b1;
      end else begin
        tcnt <= tcnt + TCNT_W'(1);
      end
    end
  end

  assign mem_we      = lat_we;
  assign mem_addr    = lat_addr;
  assign mem_wr_data = lat_wdata;
  assign i_rd_data   = rd_buf;
  assign d_rd_data   = rd_buf;
  assign err         = err_q;

endmodule
